// File: rtl/mnist_pkg.sv
// mnist_pkg: shared widths, image geometry and bank index type for the MNIST front end.
package mnist_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int EXT_ADDR_WIDTH = 10;
    localparam int IMAGE_SIZE = 28;
    localparam int PIXELS_PER_IMAGE = IMAGE_SIZE * IMAGE_SIZE;
    typedef logic bank_t;
endpackage

// File: rtl/image_bank_ram.sv
// image_bank_ram: simple dual-port RAM, one write port and one registered read port.
module image_bank_ram #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/mnist_image_buffer.sv
// mnist_image_buffer: ping-pong image memory; host streams whole images in,
// the conv layer reads the presented bank with 1-cycle latency and releases it.
module mnist_image_buffer
    import mnist_pkg::*;
#(
    parameter int DATA_WIDTH = mnist_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mnist_pkg::EXT_ADDR_WIDTH,
    parameter int IMAGE_SIZE = mnist_pkg::IMAGE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  img_ready,
    input  logic                  img_release,
    output logic                  addr_err
);
    localparam int N = IMAGE_SIZE * IMAGE_SIZE;
    bank_t                 wb, rb;
    logic [1:0]            full, full_nxt;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic                  zero_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  xfer, last, rel, in_range;
    assign wr_ready  = !rst && !full[wb];
    assign img_ready = full[rb];
    assign xfer      = wr_valid && wr_ready;
    assign last      = wcnt == ADDR_WIDTH'(N - 1);
    assign rel       = img_release && img_ready;
    // Extra bit keeps the bound intact when 2^ADDR_WIDTH == N.
    assign in_range  = {1'b0, rd_addr} < (ADDR_WIDTH + 1)'(N);
    assign rd_data   = zero_q ? '0 : ram_q;
    // Completion and release never hit the same bank, so both updates can apply.
    always_comb begin
        full_nxt = full;
        if (xfer && last) full_nxt[wb] = 1'b1;
        if (rel) full_nxt[rb] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wb       <= 1'b0;
            rb       <= 1'b0;
            full     <= 2'b00;
            wcnt     <= '0;
            zero_q   <= 1'b1;
            addr_err <= 1'b0;
        end else begin
            full <= full_nxt;
            if (xfer) begin
                wcnt <= last ? '0 : wcnt + ADDR_WIDTH'(1);
                wb   <= last ? ~wb : wb;
            end
            if (rel) rb <= ~rb;
            if (img_ready && !in_range) addr_err <= 1'b1;
            zero_q <= !(img_ready && in_range);
        end
    end
    image_bank_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH + 1)) u_ram (
        .clk  (clk),
        .we   (xfer),
        .waddr({wb, wcnt}),
        .wdata(wr_data),
        .raddr({rb, rd_addr}),
        .rdata(ram_q)
    );
endmodule
